rah_app_packetizer: RTL

Per-application framing stage that sits directly upstream of `rah_encoder`, one instance per app slot. It accepts a payload stream from application logic and buffers one complete packet locally. It then writes header, payload and XOR-checksum trailer into the encoder's per-app write FIFO (`wr_data`/`wr_clk` slice) and pulses that slot's `send_data`.

---
 rtl/rah_app_packetizer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rah_app_packetizer.sv
// rah_app_packetizer: buffers one payload packet, then frames it as header/payload/XOR trailer into the encoder FIFO slice
module rah_app_packetizer #(
  parameter int         DATA_WIDTH = 48,
  parameter logic [7:0] APP_ID     = 8'd0,
  parameter int         DEPTH      = 1024,
  parameter int         AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_prog_fifo_full,
  input  logic                  wr_fifo_full,
  output logic                  send_data,
  output logic [15:0]           pkt_len,
  output logic                  err_trunc,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, FILL, HDR, DRAIN, TRL, SEND} state_t;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] RD_ONE   = AW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  state_t                state_q, state_d;
  logic [AW:0]           wcnt_q, wcnt_d, wcnt_inc;
  logic [AW-1:0]         rcnt_q, rcnt_d, raddr;
  logic [DATA_WIDTH-1:0] csum_q, csum_d, wr_data_q, wr_data_d, rdata_q, hdr;
  logic                  s_ready_q, s_ready_d, wr_en_q, wr_en_d, send_q, send_d;
  logic                  err_trunc_q, err_trunc_d, busy_q, busy_d;
  logic [15:0]           pkt_len_q, pkt_len_d;
  logic                  accept, ok, drain_last, at_full;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // handshake, FIFO-space gate, header word and the prefetching read address
  always_comb begin
    accept     = s_valid && s_ready_q;
    ok         = !wr_prog_fifo_full && !wr_fifo_full;
    wcnt_inc   = wcnt_q + CNT_ONE;
    at_full    = wcnt_inc == FULL_CNT;
    drain_last = {1'b0, rcnt_q} == wcnt_q - CNT_ONE;
    raddr      = (state_q == DRAIN && ok) ? rcnt_q + RD_ONE : rcnt_q;
    hdr                    = '0;
    hdr[DATA_WIDTH-1 -: 8] = 8'hA5;
    hdr[DATA_WIDTH-9 -: 8] = APP_ID;
    hdr[15:0]              = 16'(wcnt_q);
  end
  // next-state and registered-output logic of the framing sequence
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    csum_d      = csum_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    send_d      = 1'b0;
    pkt_len_d   = pkt_len_q;
    err_trunc_d = 1'b0;
    case (state_q)
      IDLE, FILL: if (accept) begin
        wcnt_d      = wcnt_inc;
        csum_d      = csum_q ^ s_data;
        state_d     = (s_last || at_full) ? HDR : FILL;
        err_trunc_d = at_full && !s_last;
      end
      HDR: if (ok) begin
        wr_en_d   = 1'b1;
        wr_data_d = hdr;
        pkt_len_d = 16'(wcnt_q);
        state_d   = DRAIN;
      end
      DRAIN: if (ok) begin
        wr_en_d   = 1'b1;
        wr_data_d = rdata_q;
        rcnt_d    = drain_last ? '0 : rcnt_q + RD_ONE;
        state_d   = drain_last ? TRL : DRAIN;
      end
      TRL: if (ok) begin
        wr_en_d   = 1'b1;
        wr_data_d = csum_q;
        state_d   = SEND;
      end
      SEND: begin
        send_d  = 1'b1;
        wcnt_d  = '0;
        csum_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = (state_d == IDLE || state_d == FILL) && state_q != SEND;
    busy_d    = state_d != IDLE;
  end
  // state and output registers; reset discards any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      csum_q      <= '0;
      s_ready_q   <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      send_q      <= 1'b0;
      pkt_len_q   <= '0;
      err_trunc_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      csum_q      <= csum_d;
      s_ready_q   <= s_ready_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      send_q      <= send_d;
      pkt_len_q   <= pkt_len_d;
      err_trunc_q <= err_trunc_d;
      busy_q      <= busy_d;
    end
  end
  // payload buffer: write on accept, registered read one word ahead of DRAIN
  always_ff @(posedge clk) begin
    if (accept) mem[wcnt_q[AW-1:0]] <= s_data;
    rdata_q <= mem[raddr];
  end
  assign s_ready   = s_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign send_data = send_q;
  assign pkt_len   = pkt_len_q;
  assign err_trunc = err_trunc_q;
  assign busy      = busy_q;
endmodule
